trdb_packet_scheduler: RTL and testbench

// - Sits between trdb_priority (packet-format decisions) and the packet emitter; owns encoder start/stop sequencing.
// - Queues format requests from priority logic and trigger unit, arbitrates them and hands them to the emitter over valid/ready.
// - Maintains the resync timer (drives tc_max_resync) and the packets-lost indication (drives tc_packets_lost).

---
 rtl/trdb_pkg.sv | 52 +++++
 rtl/trdb_req_fifo.sv | 89 ++++++++
 rtl/trdb_packet_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_trdb_packet_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace debugger packet path.
package trdb_pkg;

   // Packet format carried in the header of every emitted packet.
   typedef enum logic [1:0] {
      F_OPT_EXT    = 2'h0,
      F_DIFF_DELTA = 2'h1,
      F_ADDR_ONLY  = 2'h2,
      F_SYNC       = 2'h3
   } trdb_format_e;

   // Sub-format, meaningful for F_SYNC packets.
   typedef enum logic [1:0] {
      SF_START   = 2'h0,
      SF_TRAP    = 2'h1,
      SF_CONTEXT = 2'h2,
      SF_SUPPORT = 2'h3
   } trdb_subformat_e;

   // One queued packet request handed to the emitter.
   typedef struct packed {
      trdb_format_e    format;
      trdb_subformat_e subformat;
      logic            is_trigger;
   } trdb_pkt_req_t;

   // Encoder start/stop sequencing states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      STOP  = 3'd4
   } trdb_sched_state_e;

   // Trigger unit code requesting a format 2 packet.
   localparam logic [3:0] TRIGGER_FMT2 = 4'd4;

   // Build a request entry from its fields.
   function automatic trdb_pkt_req_t make_req(input trdb_format_e    fmt,
                                              input trdb_subformat_e sub,
                                              input logic            trig);
      trdb_pkt_req_t req;
      req.format     = fmt;
      req.subformat  = sub;
      req.is_trigger = trig;
      return req;
   endfunction

   localparam trdb_pkt_req_t REQ_NONE = '{format: F_OPT_EXT, subformat: SF_START, is_trigger: 1'b0};

endpackage

// File: rtl/trdb_req_fifo.sv
// Request queue for the packet scheduler. The head entry is held in
// registers (head_valid/head_data) so the emitter interface is driven
// straight from flops; the ready input only affects next-state logic.
module trdb_req_fifo
   import trdb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  trdb_pkt_req_t push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic          head_valid,
   output trdb_pkt_req_t head_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   trdb_pkt_req_t mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_s;
   logic [PW-1:0] rd_ptr_s;
   logic          pop_ok_s;
   logic          push_ok_s;
   logic          empty_next_s;
   logic          head_valid_r;
   trdb_pkt_req_t head_data_r;
   trdb_pkt_req_t head_next_s;

   assign full       = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
   assign empty      = (wr_ptr_r == rd_ptr_r);
   assign head_valid = head_valid_r;
   assign head_data  = head_data_r;

   // Next pointers and next head; a push into the slot that becomes head is bypassed.
   always_comb begin
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
      if (pop_ok_s) begin
         rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      if (push_ok_s) begin
         wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      empty_next_s = (rd_ptr_s == wr_ptr_s);
      if (push_ok_s && (rd_ptr_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
         head_next_s = push_data;
      end else begin
         head_next_s = mem_r[rd_ptr_s[AW-1:0]];
      end
   end

   // Storage array write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= REQ_NONE;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   // Pointer and registered head update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         head_valid_r <= 1'b0;
         head_data_r  <= REQ_NONE;
      end else begin
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         head_valid_r <= ~empty_next_s;
         head_data_r  <= head_next_s;
      end
   end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Packet scheduler: sequences encoder start/stop sync packets, arbitrates
// priority-logic and trigger requests into a queue feeding the emitter,
// and maintains the resync timer and the sticky packets-lost flag.
module trdb_packet_scheduler
   import trdb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int RESYNC_MAX = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enc_enable_i,
   input  logic       qualified_i,
   input  logic       prio_valid_i,
   input  logic [1:0] prio_format_i,
   input  logic [1:0] prio_subformat_i,
   input  logic [3:0] trigger_i,
   output logic       notify_o,
   output logic       max_resync_o,
   output logic       packets_lost_o,
   output logic       enc_active_o,
   output logic       pkt_valid_o,
   input  logic       pkt_ready_i,
   output logic [1:0] pkt_format_o,
   output logic [1:0] pkt_subformat_o
);

   localparam int CW = $clog2(RESYNC_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(RESYNC_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   trdb_sched_state_e state_r;
   trdb_sched_state_e state_s;
   logic              push_s;
   trdb_pkt_req_t     push_data_s;
   logic              pop_s;
   logic              enq_ok_s;
   logic              enq_trig_s;
   logic              drop_s;
   logic              clear_lost_s;
   logic              clear_cnt_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              head_valid_s;
   trdb_pkt_req_t     head_data_s;
   logic              trig_pend_r;
   logic              lost_r;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_s;
   logic              max_r;
   logic              enc_active_r;

   trdb_req_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .head_valid(head_valid_s),
      .head_data (head_data_s)
   );

   assign pop_s           = head_valid_s & pkt_ready_i;
   assign enq_ok_s        = push_s & (~fifo_full_s | pop_s);
   assign pkt_valid_o     = head_valid_s;
   assign pkt_format_o    = head_data_s.format;
   assign pkt_subformat_o = head_data_s.subformat;
   // Notification coincides with the emitter accepting a trigger entry.
   assign notify_o        = pop_s & head_data_s.is_trigger;
   assign max_resync_o    = max_r;
   assign packets_lost_o  = lost_r;
   assign enc_active_o    = enc_active_r;

   // Next-state, enqueue arbitration (prio beats pending trigger) and drop detection.
   always_comb begin
      state_s     = state_r;
      push_s      = 1'b0;
      push_data_s = REQ_NONE;
      enq_trig_s  = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (enc_enable_i) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            push_s      = 1'b1;
            push_data_s = make_req(F_SYNC, SF_SUPPORT, 1'b0);
            if (enq_ok_s) begin
               state_s = RUN;
            end else begin
               state_s = START;
            end
         end
         RUN: begin
            if (prio_valid_i) begin
               push_s      = 1'b1;
               push_data_s = make_req(trdb_format_e'(prio_format_i),
                                      trdb_subformat_e'(prio_subformat_i), 1'b0);
               drop_s      = ~enq_ok_s;
            end else if (trig_pend_r) begin
               // A blocked trigger simply stays pending; it is never counted as lost.
               push_s      = 1'b1;
               push_data_s = make_req(F_ADDR_ONLY, SF_START, 1'b1);
               enq_trig_s  = enq_ok_s;
            end else begin
               push_s = 1'b0;
            end
            if (!enc_enable_i) begin
               state_s = DRAIN;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            if (fifo_empty_s) begin
               push_s      = 1'b1;
               push_data_s = make_req(F_SYNC, SF_SUPPORT, 1'b0);
               state_s     = STOP;
            end else begin
               state_s = DRAIN;
            end
         end
         STOP: begin
            // Only the stop entry can be queued here, so its acceptance ends the session.
            if (pop_s) begin
               state_s = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Side effects of a successful enqueue on the flag and timer.
   always_comb begin
      clear_lost_s = enq_ok_s && (push_data_s.format == F_SYNC) &&
                     (push_data_s.subformat == SF_SUPPORT);
      clear_cnt_s  = enq_ok_s && (push_data_s.format == F_SYNC) &&
                     ((push_data_s.subformat == SF_START) || (push_data_s.subformat == SF_TRAP));
   end

   // Resync timer next value: clear beats increment, saturates at RESYNC_MAX.
   always_comb begin
      cnt_s = cnt_r;
      if (state_r == IDLE) begin
         cnt_s = '0;
      end else if (clear_cnt_s) begin
         cnt_s = '0;
      end else if ((state_r == RUN) && qualified_i && (cnt_r != CNT_MAX)) begin
         cnt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // FSM state register and registered status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         max_r        <= 1'b0;
         enc_active_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         max_r        <= (cnt_s == CNT_MAX);
         enc_active_r <= (state_s == RUN);
      end
   end

   // Trigger pending: set in RUN, cleared on enqueue of its F2 entry (repeats merge).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         trig_pend_r <= 1'b0;
      end else if (state_r == IDLE) begin
         trig_pend_r <= 1'b0;
      end else if (enq_trig_s) begin
         trig_pend_r <= 1'b0;
      end else if ((state_r == RUN) && (trigger_i == TRIGGER_FMT2)) begin
         trig_pend_r <= 1'b1;
      end
   end

   // Sticky packets-lost flag, reported and cleared by the next support packet.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lost_r <= 1'b0;
      end else if (drop_s) begin
         lost_r <= 1'b1;
      end else if (clear_lost_s) begin
         lost_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed bench for trdb_packet_scheduler with a queue-based scoreboard:
// stimulus pushes expected {format, subformat, is_trigger}; a negedge
// monitor pops and compares on every emitter handshake.
module tb_trdb_packet_scheduler;

   logic       clk;
   logic       rst;
   logic       enc_enable;
   logic       qualified;
   logic       prio_valid;
   logic [1:0] prio_format;
   logic [1:0] prio_subformat;
   logic [3:0] trigger;
   logic       notify;
   logic       max_resync;
   logic       packets_lost;
   logic       enc_active;
   logic       pkt_valid;
   logic       pkt_ready;
   logic [1:0] pkt_format;
   logic [1:0] pkt_subformat;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_hs = 0;
   int         prev_hs = 0;
   logic [4:0] exp_q[$];
   logic [4:0] exp_e;

   trdb_packet_scheduler #(
      .FIFO_DEPTH(4),
      .RESYNC_MAX(64)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .enc_enable_i    (enc_enable),
      .qualified_i     (qualified),
      .prio_valid_i    (prio_valid),
      .prio_format_i   (prio_format),
      .prio_subformat_i(prio_subformat),
      .trigger_i       (trigger),
      .notify_o        (notify),
      .max_resync_o    (max_resync),
      .packets_lost_o  (packets_lost),
      .enc_active_o    (enc_active),
      .pkt_valid_o     (pkt_valid),
      .pkt_ready_i     (pkt_ready),
      .pkt_format_o    (pkt_format),
      .pkt_subformat_o (pkt_subformat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pkt(input logic [1:0] f, input logic [1:0] sf, input logic t);
      exp_q.push_back({f, sf, t});
   endtask

   task automatic drive_prio(input logic v, input logic [1:0] f, input logic [1:0] sf);
      prio_valid     = v;
      prio_format    = f;
      prio_subformat = sf;
   endtask

   // Monitor: compare every accepted packet against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (!rst && pkt_valid && pkt_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt: got fmt %0d sf %0d, expected none", pkt_format, pkt_subformat);
         end else begin
            exp_e = exp_q.pop_front();
            check("pkt_format", {30'd0, pkt_format}, {30'd0, exp_e[4:3]});
            check("pkt_subformat", {30'd0, pkt_subformat}, {30'd0, exp_e[2:1]});
            check("notify", {31'd0, notify}, {31'd0, exp_e[0]});
         end
         prev_hs = last_hs;
         last_hs = cyc;
      end else if (notify) begin
         checks++;
         errors++;
         $display("FAIL notify_without_handshake: got 1 expected 0 at %0t", $time);
      end
   end

   initial begin
      rst = 1'b1;
      enc_enable = 1'b0;
      qualified = 1'b0;
      drive_prio(1'b0, 2'd0, 2'd0);
      trigger = 4'd0;
      pkt_ready = 1'b0;

      // Reset: all outputs low.
      repeat (3) tick();
      check("rst_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_active", {31'd0, enc_active}, 32'd0);
      check("rst_lost", {31'd0, packets_lost}, 32'd0);
      check("rst_max", {31'd0, max_resync}, 32'd0);
      check("rst_notify", {31'd0, notify}, 32'd0);
      rst = 1'b0;
      tick();

      // Start: one F3/SF_SUPPORT packet, enc_active after the enqueue edge.
      enc_enable = 1'b1;
      pkt_ready = 1'b1;
      expect_pkt(2'd3, 2'd3, 1'b0);
      tick();
      check("start_active_early", {31'd0, enc_active}, 32'd0);
      tick();
      check("start_active", {31'd0, enc_active}, 32'd1);
      check("start_valid", {31'd0, pkt_valid}, 32'd1);
      repeat (3) tick();
      check("start_idle_valid", {31'd0, pkt_valid}, 32'd0);

      // Prio F1 and trigger together: F1 then F2 back to back, notify with F2.
      drive_prio(1'b1, 2'd1, 2'd0);
      trigger = 4'd4;
      expect_pkt(2'd1, 2'd0, 1'b0);
      expect_pkt(2'd2, 2'd0, 1'b1);
      tick();
      drive_prio(1'b0, 2'd0, 2'd0);
      trigger = 4'd0;
      repeat (4) tick();
      check("f1_f2_consecutive", last_hs - prev_hs, 32'd1);

      // Overflow: 5 requests into 4 entries with emitter stalled.
      pkt_ready = 1'b0;
      drive_prio(1'b1, 2'd1, 2'd1); expect_pkt(2'd1, 2'd1, 1'b0); tick();
      drive_prio(1'b1, 2'd2, 2'd2); expect_pkt(2'd2, 2'd2, 1'b0); tick();
      drive_prio(1'b1, 2'd1, 2'd3); expect_pkt(2'd1, 2'd3, 1'b0); tick();
      drive_prio(1'b1, 2'd0, 2'd1); expect_pkt(2'd0, 2'd1, 1'b0); tick();
      check("lost_before_drop", {31'd0, packets_lost}, 32'd0);
      drive_prio(1'b1, 2'd2, 2'd0); tick();
      drive_prio(1'b0, 2'd0, 2'd0);
      check("lost_set", {31'd0, packets_lost}, 32'd1);
      pkt_ready = 1'b1;
      repeat (6) tick();
      check("lost_sticky", {31'd0, packets_lost}, 32'd1);
      drive_prio(1'b1, 2'd3, 2'd3); expect_pkt(2'd3, 2'd3, 1'b0); tick();
      drive_prio(1'b0, 2'd0, 2'd0);
      check("lost_cleared", {31'd0, packets_lost}, 32'd0);
      repeat (3) tick();

      // Resync timer: 64 qualified cycles, then saturate, then clear by F3/SF_START.
      qualified = 1'b1;
      repeat (63) tick();
      check("max_at_63", {31'd0, max_resync}, 32'd0);
      tick();
      check("max_at_64", {31'd0, max_resync}, 32'd1);
      tick();
      check("max_saturated", {31'd0, max_resync}, 32'd1);
      drive_prio(1'b1, 2'd3, 2'd0); expect_pkt(2'd3, 2'd0, 1'b0); tick();
      drive_prio(1'b0, 2'd0, 2'd0);
      check("max_cleared", {31'd0, max_resync}, 32'd0);
      tick();
      check("max_after_one", {31'd0, max_resync}, 32'd0);
      qualified = 1'b0;
      repeat (3) tick();

      // Drain: 3 queued, prio during DRAIN ignored, then stop packet and IDLE.
      pkt_ready = 1'b0;
      drive_prio(1'b1, 2'd1, 2'd0); expect_pkt(2'd1, 2'd0, 1'b0); tick();
      drive_prio(1'b1, 2'd2, 2'd1); expect_pkt(2'd2, 2'd1, 1'b0); tick();
      drive_prio(1'b1, 2'd0, 2'd2); expect_pkt(2'd0, 2'd2, 1'b0); tick();
      drive_prio(1'b0, 2'd0, 2'd0);
      enc_enable = 1'b0;
      tick();
      check("drain_active", {31'd0, enc_active}, 32'd0);
      drive_prio(1'b1, 2'd1, 2'd1);
      repeat (3) tick();
      check("drain_hold_valid", {31'd0, pkt_valid}, 32'd1);
      check("drain_hold_fmt", {30'd0, pkt_format}, 32'd1);
      check("drain_hold_sf", {30'd0, pkt_subformat}, 32'd0);
      expect_pkt(2'd3, 2'd3, 1'b0);
      pkt_ready = 1'b1;
      repeat (10) tick();
      drive_prio(1'b0, 2'd0, 2'd0);
      check("drain_idle_valid", {31'd0, pkt_valid}, 32'd0);
      check("drain_idle_active", {31'd0, enc_active}, 32'd0);
      check("drain_no_lost", {31'd0, packets_lost}, 32'd0);

      // Reset mid-handshake: valid drops asynchronously, queue empty afterwards.
      pkt_ready = 1'b0;
      enc_enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!pkt_valid) tick();
      end
      check("rst_mid_setup_valid", {31'd0, pkt_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_async_active", {31'd0, enc_active}, 32'd0);
      enc_enable = 1'b0;
      pkt_ready = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_valid", {31'd0, pkt_valid}, 32'd0);
      check("post_rst_lost", {31'd0, packets_lost}, 32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
